// File: rtl/enemy_missile_pkg.sv
// Shared enemy-missile types and playfield constants, also used by the
// renderer and collision logic.
package enemy_missile_pkg;

  typedef enum logic {
    SLOT_IDLE    = 1'b0,
    SLOT_FALLING = 1'b1
  } slot_state_t;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int SCREEN_W = 640;
  localparam int GROUND_Y = 440;

endpackage

// File: rtl/enemy_missile_slot.sv
// One enemy missile slot: IDLE/FALLING state plus its X/Y coordinates.
// All changes happen only on a frame tick; kill beats a ground hit.
module enemy_missile_slot
  import enemy_missile_pkg::*;
#(
  parameter int X_W       = enemy_missile_pkg::X_W,
  parameter int Y_W       = enemy_missile_pkg::Y_W,
  parameter int START_Y   = 0,
  parameter int GROUND_Y  = enemy_missile_pkg::GROUND_Y,
  parameter int FALL_STEP = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           kill,
  input  logic           spawn,
  input  logic [X_W-1:0] seed_x,
  output logic           active,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hit
);

  slot_state_t    state;
  slot_state_t    state_nxt;
  logic [Y_W:0]   y_next;
  logic           ground;

  // One extra bit so the ground compare cannot wrap
  assign y_next = {1'b0, y} + (Y_W+1)'(FALL_STEP);
  assign ground = (y_next >= (Y_W+1)'(GROUND_Y));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SLOT_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: spawn only from IDLE, kill or ground hit only from FALLING
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        SLOT_IDLE:    if (spawn) state_nxt = SLOT_FALLING;
        SLOT_FALLING: if (kill || ground) state_nxt = SLOT_IDLE;
        default:      state_nxt = SLOT_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    active = (state == SLOT_FALLING);
  end

  // Coordinates and one-clock ground-hit pulse; a killed missile never reports a hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      hit <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (tick) begin
        case (state)
          SLOT_IDLE: begin
            if (spawn) begin
              x <= seed_x;
              y <= Y_W'(START_Y);
            end
          end
          SLOT_FALLING: begin
            if (!kill) begin
              if (ground) begin
                y   <= Y_W'(GROUND_Y);
                hit <= 1'b1;
              end else begin
                y <= y_next[Y_W-1:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/enemy_missile_spawner.sv
// Turns the serial spawn-bit stream into falling enemy missiles: keeps a
// free-running X seed, picks the lowest idle slot on a spawn, and reports
// ground impacts and dropped spawns as one-clock pulses.
module enemy_missile_spawner
  import enemy_missile_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int X_W       = enemy_missile_pkg::X_W,
  parameter int Y_W       = enemy_missile_pkg::Y_W,
  parameter int SCREEN_W  = enemy_missile_pkg::SCREEN_W,
  parameter int X_STEP    = 137,
  parameter int START_Y   = 0,
  parameter int GROUND_Y  = enemy_missile_pkg::GROUND_Y,
  parameter int FALL_STEP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     spawn_bit,
  input  logic [NUM_SLOTS-1:0]     kill,
  output logic [NUM_SLOTS-1:0]     active,
  output logic [NUM_SLOTS*X_W-1:0] missile_x,
  output logic [NUM_SLOTS*Y_W-1:0] missile_y,
  output logic                     impact,
  output logic [NUM_SLOTS-1:0]     impact_mask,
  output logic                     spawn_drop
);

  logic [X_W:0]         x_seed;
  logic [X_W:0]         seed_sum;
  logic [NUM_SLOTS-1:0] free_mask;
  logic [NUM_SLOTS-1:0] lowest_free;
  logic                 spawn_req;

  assign seed_sum = x_seed + (X_W+1)'(X_STEP);

  // Free-running X seed, wrapped into 0..SCREEN_W-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_seed <= '0;
    end else if (seed_sum >= (X_W+1)'(SCREEN_W)) begin
      x_seed <= seed_sum - (X_W+1)'(SCREEN_W);
    end else begin
      x_seed <= seed_sum;
    end
  end

  // Eligibility uses slot state at the start of the tick, so a slot freed
  // on this tick cannot be reused until the next one.
  assign spawn_req   = frame_tick & spawn_bit;
  assign free_mask   = ~active;
  assign lowest_free = free_mask & (~free_mask + NUM_SLOTS'(1));

  // Spawn request with every slot busy is dropped and flagged for one clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) spawn_drop <= 1'b0;
    else     spawn_drop <= spawn_req & (&active);
  end

  assign impact = |impact_mask;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    enemy_missile_slot #(
      .X_W       (X_W),
      .Y_W       (Y_W),
      .START_Y   (START_Y),
      .GROUND_Y  (GROUND_Y),
      .FALL_STEP (FALL_STEP)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .tick   (frame_tick),
      .kill   (kill[i]),
      .spawn  (spawn_req & lowest_free[i]),
      .seed_x (x_seed[X_W-1:0]),
      .active (active[i]),
      .x      (missile_x[i*X_W +: X_W]),
      .y      (missile_y[i*Y_W +: Y_W]),
      .hit    (impact_mask[i])
    );
  end

endmodule

// File: tb/tb_enemy_missile_spawner.sv
// Testbench for enemy_missile_spawner: directed scenarios plus randomized
// traffic, checked against a slot-list reference model.
module tb_enemy_missile_spawner;

  localparam int NS        = 4;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int SCREEN_W  = 640;
  localparam int X_STEP    = 137;
  localparam int START_Y   = 0;
  localparam int GROUND_Y  = 440;
  localparam int FALL_STEP = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                frame_tick = 1'b0;
  logic                spawn_bit = 1'b0;
  logic [NS-1:0]       kill = '0;
  logic [NS-1:0]       active;
  logic [NS*X_W-1:0]   missile_x;
  logic [NS*Y_W-1:0]   missile_y;
  logic                impact;
  logic [NS-1:0]       impact_mask;
  logic                spawn_drop;

  enemy_missile_spawner #(
    .NUM_SLOTS (NS),
    .X_W       (X_W),
    .Y_W       (Y_W),
    .SCREEN_W  (SCREEN_W),
    .X_STEP    (X_STEP),
    .START_Y   (START_Y),
    .GROUND_Y  (GROUND_Y),
    .FALL_STEP (FALL_STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .spawn_bit   (spawn_bit),
    .kill        (kill),
    .active      (active),
    .missile_x   (missile_x),
    .missile_y   (missile_y),
    .impact      (impact),
    .impact_mask (impact_mask),
    .spawn_drop  (spawn_drop)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of slots with plain integer coordinates
  bit m_act [NS];
  int m_x   [NS];
  int m_y   [NS];
  int m_seed;
  logic [NS-1:0] e_mask;
  logic          e_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_act();
    logic [63:0] v = '0;
    for (int i = 0; i < NS; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_coord(input bit is_x);
    logic [63:0] v = '0;
    for (int i = 0; i < NS; i++)
      v = v | (64'(is_x ? m_x[i] : m_y[i]) << (i * (is_x ? X_W : Y_W)));
    return v;
  endfunction

  task automatic compare_all();
    check("active",      64'(active),      pack_act());
    check("missile_x",   64'(missile_x),   pack_coord(1'b1));
    check("missile_y",   64'(missile_y),   pack_coord(1'b0));
    check("impact_mask", 64'(impact_mask), 64'(e_mask));
    check("impact",      64'(impact),      64'(|e_mask));
    check("spawn_drop",  64'(spawn_drop),  64'(e_drop));
  endtask

  // Apply one clock of inputs, advance the model, compare after the edge
  task automatic step(input logic t, input logic sb, input logic [NS-1:0] kl);
    int target;
    frame_tick = t;
    spawn_bit  = sb;
    kill       = kl;
    @(posedge clk);
    e_mask = '0;
    e_drop = 1'b0;
    if (t) begin
      target = -1;
      if (sb)
        for (int i = 0; i < NS; i++)
          if (!m_act[i] && target < 0) target = i;
      for (int i = 0; i < NS; i++) begin
        if (m_act[i]) begin
          if (kl[i]) begin
            m_act[i] = 1'b0;
          end else if (m_y[i] + FALL_STEP >= GROUND_Y) begin
            m_act[i]  = 1'b0;
            m_y[i]    = GROUND_Y;
            e_mask[i] = 1'b1;
          end else begin
            m_y[i] = m_y[i] + FALL_STEP;
          end
        end
      end
      if (sb) begin
        if (target >= 0) begin
          m_act[target] = 1'b1;
          m_x[target]   = m_seed;
          m_y[target]   = START_Y;
        end else begin
          e_drop = 1'b1;
        end
      end
    end
    m_seed = (m_seed + X_STEP) % SCREEN_W;
    #1;
    compare_all();
  endtask

  // Assert reset between edges, confirm outputs clear without a clock edge
  task automatic do_reset();
    frame_tick = 1'b0;
    spawn_bit  = 1'b0;
    kill       = '0;
    rst = 1'b1;
    #1;
    check("rst_active", 64'(active),      64'd0);
    check("rst_x",      64'(missile_x),   64'd0);
    check("rst_y",      64'(missile_y),   64'd0);
    check("rst_impact", 64'(impact),      64'd0);
    check("rst_mask",   64'(impact_mask), 64'd0);
    check("rst_drop",   64'(spawn_drop),  64'd0);
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_seed = 0;
    e_mask = '0;
    e_drop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int imp_cnt;
    int imp_at;
    bit reached;
    logic [NS-1:0] kl;

    do_reset();

    // Idle after reset: seed runs 0,137,274,411,548 -> 45 on the sixth clock
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, '0);
    check("spawn_active", 64'(active), 64'h1);
    check("spawn_x0",     64'(missile_x[X_W-1:0]), 64'd45);
    check("spawn_y0",     64'(missile_y[Y_W-1:0]), 64'd0);

    // Single missile falls to ground on its 220th tick
    imp_cnt = 0;
    imp_at  = 0;
    for (int n = 1; n <= 225; n++) begin
      step(1'b1, 1'b0, '0);
      if (impact) begin
        imp_cnt++;
        imp_at = n;
      end
    end
    check("impact_count", 64'(imp_cnt), 64'd1);
    check("impact_tick",  64'(imp_at),  64'd220);
    check("after_impact", 64'(active),  64'd0);

    // Fill all slots, then an extra spawn is dropped
    do_reset();
    for (int n = 0; n < NS; n++) step(1'b1, 1'b1, '0);
    check("full", 64'(active), 64'hF);
    step(1'b1, 1'b1, '0);
    check("drop_pulse",  64'(spawn_drop), 64'd1);
    check("drop_active", 64'(active),     64'hF);
    step(1'b0, 1'b1, '0);
    check("drop_clear",  64'(spawn_drop), 64'd0);

    // Slot freed by kill is not reusable on the same tick
    step(1'b1, 1'b1, 4'b0001);
    check("kill_drop",   64'(spawn_drop), 64'd1);
    check("kill_active", 64'(active),     64'hE);
    step(1'b1, 1'b1, '0);
    check("realloc",     64'(active),     64'hF);

    // Kill on the ground-hit tick suppresses the impact
    do_reset();
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    reached = 1'b0;
    for (int n = 0; n < 300 && !reached; n++) begin
      if (m_act[1] && (m_y[1] + FALL_STEP >= GROUND_Y)) reached = 1'b1;
      else step(1'b1, 1'b0, '0);
    end
    if (!reached) check("kill_setup", 64'd0, 64'd1);
    step(1'b1, 1'b0, 4'b0010);
    check("kill_gnd_active", 64'(active[1]), 64'd0);
    check("kill_gnd_impact", 64'(impact),    64'd0);

    // Reset mid-flight while an impact pulse is showing and three slots fall
    do_reset();
    for (int n = 0; n < NS; n++) step(1'b1, 1'b1, '0);
    reached = 1'b0;
    for (int n = 0; n < 300 && !reached; n++) begin
      step(1'b1, 1'b0, '0);
      if (e_mask != '0) reached = 1'b1;
    end
    check("pre_rst_impact", 64'(impact), 64'd1);
    check("pre_rst_active", 64'(active), 64'hE);
    do_reset();

    // Randomized traffic, including spawn/kill while frame_tick is low
    for (int n = 0; n < 4000; n++) begin
      kl = ($urandom_range(0, 15) == 0) ? NS'($urandom_range(0, 15)) : '0;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), kl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_missile_spawner.md
Name: enemy_missile_spawner

Overview:
Consumes the serial pseudo-random spawn-bit stream from the enemy missile shift register and turns it into live enemy missiles. On each frame tick it samples the bit. A '1' allocates a free missile slot with a starting X position. Active missiles fall toward the ground, and the block reports ground impacts and frees a slot on impact or kill. It sits between the spawn shift register and the missile renderer / collision logic.

Parameters:
NUM_SLOTS, 4, number of concurrent enemy missiles (1..8)
X_W, 10, X coordinate width
Y_W, 9, Y coordinate width
SCREEN_W, 640, X wrap limit; valid X is 0..SCREEN_W-1
X_STEP, 137, X seed increment per clk (odd, < SCREEN_W)
START_Y, 0, Y assigned at spawn
GROUND_Y, 440, Y at or beyond which a missile impacts
FALL_STEP, 2, Y increment per frame tick

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-clk pulse per video frame
spawn_bit  in  1  serial spawn stream from shift register
kill  in  NUM_SLOTS  per-slot destroy request (from collision logic), level sampled on frame_tick
active  out  NUM_SLOTS  slot holds a live missile
missile_x  out  NUM_SLOTS*X_W  packed X per slot, slot 0 in LSBs
missile_y  out  NUM_SLOTS*Y_W  packed Y per slot
impact  out  1  one-clk pulse: at least one missile reached ground this tick
impact_mask  out  NUM_SLOTS  slots that impacted this tick, valid with impact
spawn_drop  out  1  one-clk pulse: spawn requested but no free slot

Behaviour:
- Reset (async, immediate): active=0, all missile_x/missile_y=0, impact=0, impact_mask=0, spawn_drop=0, x_seed=0.
- x_seed: free-running, updated every clk. x_seed <= x_seed+X_STEP; if the sum >= SCREEN_W, subtract SCREEN_W. Width X_W+1 internally, so the value always stays in 0..SCREEN_W-1.
- All slot state changes occur only in the clk where frame_tick=1. Outputs update the following edge, so latency is 1 clk from frame_tick.
- Per-slot FSM, 2 states:
  - IDLE: active=0.
  - FALLING: active=1.
- Per slot on frame_tick, priority order:
  1. kill[i]=1 and FALLING -> IDLE, no impact. kill wins over a simultaneous ground hit. kill on an IDLE slot is ignored.
  2. FALLING and y+FALL_STEP >= GROUND_Y -> IDLE, impact_mask[i]=1, y saturates to GROUND_Y for that cycle's output.
  3. FALLING otherwise -> y <= y+FALL_STEP, x unchanged.
- Spawn on frame_tick with spawn_bit=1:
  - Target is the lowest-index slot that is IDLE at the start of the tick.
  - Slots freed during this same tick are not eligible until the next tick.
  - The target slot becomes FALLING with x=x_seed (value before this clk's update) and y=START_Y.
  - If no slot is IDLE, spawn_drop pulses 1 clk and no state changes.
- At most one spawn per frame tick.
- impact = OR of impact_mask. Both pulse for exactly 1 clk and are 0 in all other cycles.
- frame_tick held high for consecutive clks: each high clk is a separate tick (no edge detect).
- spawn_bit and kill are sampled only on frame_tick and ignored otherwise.
- Reset mid-flight clears all slots immediately and suppresses any pending impact pulse.

Decomposition:
- Shared package (enemy_missile_pkg) holds:
  - slot state enum (SLOT_IDLE, SLOT_FALLING);
  - SCREEN_W, GROUND_Y, X_W, Y_W constants, shared with the renderer and collision logic.
- Natural sub-module: enemy_missile_slot, one FSM and coordinate register pair, instantiated NUM_SLOTS times via generate.
- Top level holds x_seed, the free-slot priority encoder and the impact/spawn_drop pulse logic.

Test Plan:
- Reset release, 10 clks, no frame_tick -> active=0, impact=0, spawn_drop=0, x_seed sequence 0,137,274,411,548,45.
- spawn_bit=1 on a single frame_tick -> next clk: active=4'b0001, missile_y[0]=0, missile_x[0]=x_seed sampled at that tick.
- One missile, 220 frame_ticks (440/2) -> impact and impact_mask=0001 pulse exactly once, on tick 220, then active=0.
- Fill all 4 slots, then spawn_bit=1 again -> spawn_drop pulse 1 clk, active stays 1111.
- Same tick: slot 0 killed and spawn_bit=1 with all slots full -> slot 0 IDLE, spawn_drop=1. Next tick with spawn_bit=1 -> slot 0 reallocated.
- kill[1] asserted on the tick slot 1 would hit ground -> active[1]=0, impact stays 0.
- Assert rst while 3 missiles are falling -> all outputs 0 immediately, without waiting for a clk edge.
